// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: FSM encodings, trigger modes,
// status-word layout and the vector/priority helpers.
package irq_pkg;

    localparam int NUM_IRQ = 16;
    localparam int ID_W    = 4;
    localparam int SLOT_SH = 2;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_REQUEST = 2'b01;
    localparam logic [1:0] ST_SERVICE = 2'b10;

    typedef enum logic [1:0] {
        TRIG_LVL_HI = 2'b00,
        TRIG_LVL_LO = 2'b01,
        TRIG_RISE   = 2'b10,
        TRIG_FALL   = 2'b11
    } trig_mode_e;

    localparam int STAT_PEND_LSB  = 0;
    localparam int STAT_ID_LSB    = 16;
    localparam int STAT_STATE_LSB = 20;

    // Each vector table slot is 2**SLOT_SH bytes above {base, 8'h00}.
    function automatic logic [15:0] vector_addr(input logic [7:0] base, input logic [ID_W-1:0] id);
        return {base, 8'h00} + (16'(id) << SLOT_SH);
    endfunction

    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-side request/acknowledge/return handshake of the interrupt controller.
interface irq_cpu_if;

    logic        irq_req;
    logic [15:0] irq_vector;
    logic        irq_ack;
    logic        irq_ret;

    modport master (
        output irq_req,
        output irq_vector,
        input  irq_ack,
        input  irq_ret
    );

    modport slave (
        input  irq_req,
        input  irq_vector,
        output irq_ack,
        output irq_ret
    );

endinterface

// File: rtl/irq_line_qual.sv
// One interrupt line: history flop plus trigger-mode decode into an edge-set
// strobe and a qualified level.
module irq_line_qual
    import irq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       line_i,
    input  logic [1:0] mode_i,
    output logic       set_pend,
    output logic       level_pend
);

    logic hist_q;
    logic hist_d;

    always_comb hist_d = line_i;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) hist_q <= 1'b0;
        else       hist_q <= hist_d;
    end

    always_comb begin
        // NOTE: outputs get a default first so no branch can leave them unassigned (no latch).
        set_pend   = 1'b0;
        level_pend = 1'b0;
        case (trig_mode_e'(mode_i))
            TRIG_LVL_HI: level_pend = line_i;
            TRIG_LVL_LO: level_pend = ~line_i;
            TRIG_RISE:   set_pend   = ~hist_q & line_i;
            TRIG_FALL:   set_pend   = hist_q & ~line_i;
            default:     ;
        endcase
    end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: pending vector, lowest-index arbitration,
// request/service FSM and vector register. Define IRQ_SYNC_EN to add a 2-flop input synchroniser.
module interrupt_controller
    import irq_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_IRQ-1:0]   irq_lines,
    input  logic                 int_en,
    input  logic [NUM_IRQ-1:0]   irq_mask,
    input  logic [2*NUM_IRQ-1:0] trig_mode,
    input  logic [7:0]           vector_base,
    irq_cpu_if.master            cpu,
    output logic [31:0]          irq_status
);

    logic [NUM_IRQ-1:0] lines_s;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync1_d;
    logic [NUM_IRQ-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq_lines;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign lines_s = sync2_q;
`else
    assign lines_s = irq_lines;
`endif

    logic [NUM_IRQ-1:0] set_pend;
    logic [NUM_IRQ-1:0] level_pend;
    logic [NUM_IRQ-1:0] edge_mode;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_line_qual u_qual (
            .clock      (clock),
            .reset      (reset),
            .line_i     (lines_s[g]),
            .mode_i     (trig_mode[2*g +: 2]),
            .set_pend   (set_pend[g]),
            .level_pend (level_pend[g])
        );
        assign edge_mode[g] = trig_mode[2*g+1];
    end

    logic [1:0]         state_q, state_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [15:0]        vec_q, vec_d;
    logic               req_q, req_d;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;

    always_comb begin
        eligible = pend_q & irq_mask;
        state_d  = state_q;
        id_d     = id_q;
        vec_d    = vec_q;
        req_d    = req_q;
        ack_clr  = '0;

        case (state_q)
            ST_IDLE: begin
                if (int_en && (eligible != '0)) begin
                    state_d = ST_REQUEST;
                    id_d    = lowest_set(eligible);
                    vec_d   = vector_addr(vector_base, id_d);
                    req_d   = 1'b1;
                end
            end
            ST_REQUEST: begin
                // An ack wins over a same-cycle withdrawal: the CPU already took the vector.
                if (cpu.irq_ack) begin
                    state_d = ST_SERVICE;
                    req_d   = 1'b0;
                    if (edge_mode[id_q]) ack_clr[id_q] = 1'b1;
                end else if (!int_en || !irq_mask[id_q]) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (cpu.irq_ret) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Edge lines are sticky with set beating clear; level lines track the qualified level.
        pend_d = (edge_mode & (set_pend | (pend_q & ~ack_clr))) | (~edge_mode & level_pend);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            id_q    <= '0;
            vec_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            req_q   <= req_d;
        end
    end

    assign cpu.irq_req    = req_q;
    assign cpu.irq_vector = vec_q;

    always_comb begin
        irq_status = '0;
        irq_status[STAT_PEND_LSB  +: NUM_IRQ] = pend_q;
        irq_status[STAT_ID_LSB    +: ID_W]    = id_q;
        irq_status[STAT_STATE_LSB +: 2]       = state_q;
    end

endmodule
